// File: rtl/cla_nibble_seq.sv
// cla_nibble_seq: multi-cycle WIDTH-bit adder built on a 4-bit carry-lookahead cell.
// An operand pair is accepted over a valid/ready handshake. It is added one
// nibble per clock, LSB nibble first. The result is then offered on a second
// valid/ready handshake.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand pair and cin presented
//   in_ready   block can accept operands (IDLE)
//   a, b       WIDTH-bit operands
//   cin        carry into bit 0
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts result
//   sum        registered WIDTH-bit result
//   cout       registered carry out of bit WIDTH-1
//   busy       high in RUN or DONE
//   ovf        signed overflow of the add (only with CLA_NIBBLE_SEQ_OVF_EN)
//
// Optional feature macro: CLA_NIBBLE_SEQ_OVF_EN adds the ovf output.
// WIDTH must be a multiple of 4 and at least 8; NIBBLES is derived and must not be overridden.

module cla_nibble_seq #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned NIBBLES = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef CLA_NIBBLE_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic             w_in_ready_nx;
  logic             w_out_valid_nx;
  logic             w_busy_nx;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_carry;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_accept;
  logic             w_run;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_fin;

  // CLA cell signals: index 0 is x1/y1/z1 (nibble bit 0), index 3 is x4/y4/z4
  logic [3:0]       w_x;
  logic [3:0]       w_y;
  logic [3:0]       w_g;
  logic [3:0]       w_p;
  logic [4:0]       w_c;
  logic [3:0]       w_z;
  logic             w_cout;

  // 4-bit carry-lookahead cell: operand low nibbles in, carry register as cin
  always_comb begin
    w_x    = r_a_sh[3:0];
    w_y    = r_b_sh[3:0];
    w_g    = w_x & w_y;
    w_p    = w_x ^ w_y;
    w_c[0] = r_carry;
    w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
           | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
           | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    w_z    = w_p ^ w_c[3:0];
    w_cout = w_c[4];
  end

  assign w_accept  = (r_state == S_IDLE) && in_valid;
  assign w_run     = (r_state == S_RUN);
  assign w_last    = w_run && (r_count == LAST_CNT);
  // Sum shift register contents after the final nibble lands
  assign w_sum_fin = {w_z, r_sum_sh[WIDTH-1:4]};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next state and next values of the registered handshake/status outputs
  always_comb begin
    w_state_nx     = r_state;
    w_in_ready_nx  = 1'b0;
    w_out_valid_nx = 1'b0;
    w_busy_nx      = 1'b0;
    case (r_state)
      S_IDLE:  if (in_valid)             w_state_nx = S_RUN;
      S_RUN:   if (r_count == LAST_CNT)  w_state_nx = S_DONE;
      S_DONE:  if (out_ready)            w_state_nx = S_IDLE;
      default:                           w_state_nx = S_IDLE;
    endcase
    case (w_state_nx)
      S_IDLE:  w_in_ready_nx = 1'b1;
      S_RUN:   w_busy_nx     = 1'b1;
      S_DONE: begin
        w_busy_nx      = 1'b1;
        w_out_valid_nx = 1'b1;
      end
      default: w_in_ready_nx = 1'b1;
    endcase
  end

  // Output flags track the state register one-for-one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_in_ready  <= w_in_ready_nx;
      r_out_valid <= w_out_valid_nx;
      r_busy      <= w_busy_nx;
    end
  end

  // Operand capture and nibble-serial datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_count  <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else if (w_accept) begin
      r_a_sh  <= a;
      r_b_sh  <= b;
      r_carry <= cin;
      r_count <= '0;
    end else if (w_run) begin
      r_sum_sh <= w_sum_fin;
      r_a_sh   <= r_a_sh >> 4;
      r_b_sh   <= r_b_sh >> 4;
      r_carry  <= w_cout;
      r_count  <= r_count + CW'(1);
      if (w_last) begin
        r_sum  <= w_sum_fin;
        r_cout <= w_cout;
      end
    end
  end

`ifdef CLA_NIBBLE_SEQ_OVF_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  // Operand sign bits are kept because the shifters lose them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= b[WIDTH-1];
    end else if (w_last) begin
      r_ovf <= (r_a_msb == r_b_msb) && (w_sum_fin[WIDTH-1] != r_a_msb);
    end
  end

  assign ovf = r_ovf;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule

// File: tb/tb_cla_nibble_seq.sv
// Directed bench for cla_nibble_seq (WIDTH=16): a vector table of single adds, then
// hand-written backpressure, mid-run reset and back-to-back sequences.
module tb_cla_nibble_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        busy;
`ifdef CLA_NIBBLE_SEQ_OVF_EN
  logic        ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  cla_nibble_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef CLA_NIBBLE_SEQ_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_ready();
    int wt = 0;
    while (!in_ready && wt < 20) begin
      @(negedge clk);
      wt++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'(1));
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // One add with out_ready held high; checks latency, result and one-cycle out_valid
  task automatic run_add(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                         input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    wait_ready();
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = ~ta; b = 16'($urandom); cin = ~tc;
    chk("busy_after_accept", 32'(busy), 32'(1));
    wait_valid(lat);
    chk("latency", 32'(lat), 32'(4));
    chk("sum", 32'(sum), 32'(es));
    chk("cout", 32'(cout), 32'(ec));
`ifdef CLA_NIBBLE_SEQ_OVF_EN
    chk("ovf", 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("unused");
`endif
    @(negedge clk);
    chk("out_valid_one_cycle", 32'(out_valid), 32'(0));
    chk("in_ready_after_handoff", 32'(in_ready), 32'(1));
  endtask

  initial begin
    int lat;
    int acc[3];
    logic seen;
    logic [15:0] pa[3];
    logic [15:0] pb[3];
    logic        pc[3];
    logic [15:0] ps[3];
    logic        pco[3];

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h0003, 16'hFFFF, 1'b0, 16'h0002, 1'b1, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[8] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[9] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0};

    pa[0] = 16'h1111; pb[0] = 16'h2222; pc[0] = 1'b0; ps[0] = 16'h3333; pco[0] = 1'b0;
    pa[1] = 16'hF000; pb[1] = 16'h1000; pc[1] = 1'b1; ps[1] = 16'h0001; pco[1] = 1'b1;
    pa[2] = 16'h0F0F; pb[2] = 16'h00F1; pc[2] = 1'b0; ps[2] = 16'h1000; pco[2] = 1'b0;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_sum", 32'(sum), 32'(0));
    chk("rst_cout", 32'(cout), 32'(0));
`ifdef CLA_NIBBLE_SEQ_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'(0));
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'(1));

    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      run_add(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].s, vecs[i].co, vecs[i].ov);
    end

    // Backpressure: result must hold in DONE and in_valid must be ignored
    out_ready = 1'b0;
    wait_ready();
    a = 16'h00F0; b = 16'h0F10; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(lat);
    chk("bp_latency", 32'(lat), 32'(4));
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 32'(out_valid), 32'(1));
      chk("bp_in_ready", 32'(in_ready), 32'(0));
      chk("bp_sum", 32'(sum), 32'(16'h1000));
      chk("bp_cout", 32'(cout), 32'(0));
      if (i == 1) begin
        in_valid = 1'b1; a = 16'h1111; b = 16'h1111;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bp_still_done", 32'(out_valid), 32'(1));
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(out_valid), 32'(0));
    chk("bp_release_ready", 32'(in_ready), 32'(1));
    chk("bp_release_busy", 32'(busy), 32'(0));

    // Reset during the second RUN cycle aborts the operation
    wait_ready();
    a = 16'hABCD; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'(0));
    chk("arst_sum", 32'(sum), 32'(0));
    chk("arst_in_ready", 32'(in_ready), 32'(1));
    chk("arst_busy", 32'(busy), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("arst_no_out_valid", 32'(seen), 32'(0));
    chk("arst_ready_after", 32'(in_ready), 32'(1));
    run_add(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);

    // Back-to-back with in_valid held high: accepts only in IDLE, every 6 cycles
    out_ready = 1'b1;
    a = pa[0]; b = pb[0]; cin = pc[0]; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_ready();
      @(negedge clk);
      acc[i] = cyc;
      if (i < 2) begin
        a = pa[i+1]; b = pb[i+1]; cin = pc[i+1];
      end else begin
        in_valid = 1'b0;
      end
      wait_valid(lat);
      chk("b2b_latency", 32'(lat), 32'(4));
      chk("b2b_sum", 32'(sum), 32'(ps[i]));
      chk("b2b_cout", 32'(cout), 32'(pco[i]));
      @(negedge clk);
    end
    chk("b2b_spacing_01", 32'(acc[1] - acc[0]), 32'(6));
    chk("b2b_spacing_12", 32'(acc[2] - acc[1]), 32'(6));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cla_nibble_seq.md
Name: cla_nibble_seq

Overview:
Multi-cycle WIDTH-bit adder built around the team's 4-bit carry-lookahead cell (cla).
- Accepts one operand pair through a valid/ready handshake.
- Feeds the 4-bit CLA one nibble per clock, LSB nibble first.
- Registers each nibble sum and the 4-bit carry-out, then presents the full-width result through a second valid/ready handshake.
- Sits directly upstream and downstream of the CLA slice: it drives x1..x4/y1..y4/cin and consumes z1..z4/cout.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- NIBBLES, WIDTH/4, derived; number of CLA passes per operation; not to be overridden.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair and cin presented.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in to bit 0.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  registered result.
- cout  out  1  registered carry-out of bit WIDTH-1.
- busy  out  1  high while in RUN or DONE.

Behaviour:
Reset and clocking:
- Single clock domain (clk). rst is asynchronous, active-high.
- While rst is high: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0; all internal operand, carry and count registers are 0.

Bit mapping to the CLA cell:
- x1/y1/z1 = nibble bit 0, x4/y4/z4 = nibble bit 3.
- CLA cin = carry register.
- CLA cout = next carry.

FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, busy=0, out_valid=0.
  - On in_valid=1 at a clock edge: latch a into a_sh, b into b_sh, cin into carry reg; count=0; go to RUN.
- RUN (one nibble per cycle):
  - in_ready=0, busy=1.
  - Each edge: sum_sh <= {z4..z1, sum_sh[WIDTH-1:4]}; a_sh and b_sh shift right by 4; carry <= CLA cout; count++.
  - On the edge where count==NIBBLES-1: go to DONE; sum <= completed sum_sh contents; cout <= final CLA cout.
- DONE:
  - out_valid=1, busy=1, in_ready=0.
  - sum and cout hold stable until out_valid&&out_ready at an edge, then go to IDLE.
  - in_valid is ignored in DONE and RUN; there is no queuing.

Latency:
- Input accepted at edge k.
- out_valid rises after edge k+NIBBLES (4 cycles for WIDTH=16).
- Minimum issue interval: NIBBLES+2 cycles (accept, NIBBLES passes, handoff, return to IDLE).

Arithmetic:
- Unsigned modulo 2^WIDTH.
- {cout,sum} = a+b+cin, exact for all inputs.

Boundary conditions:
- Full-length carry ripple (e.g. all-ones + 1) must propagate through every nibble via the carry register.
- out_ready held high on entry to DONE: result is consumed on the first DONE edge; out_valid is high for exactly one cycle.
- out_ready asserted while not in DONE: no effect.
- rst asserted mid-RUN or mid-DONE: operation is aborted, no out_valid is produced, all outputs return to reset values immediately (asynchronously).
- Operands a/b/cin may change freely after acceptance; only latched copies are used.

Optional Feature:
Macro CLA_NIBBLE_SEQ_OVF_EN.
- Defined:
  - Adds output port ovf (out, 1): signed two's-complement overflow of the WIDTH-bit add.
  - ovf = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]). Operand MSBs are captured at input acceptance.
  - ovf is registered alongside sum, is valid with out_valid, holds in DONE, and resets to 0.
- Undefined: no ovf port and no extra registers; all other behaviour is identical.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, cin=0, out_ready=1 -> sum=0x5555, cout=0; out_valid high exactly 4 cycles after accept, for 1 cycle.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry crosses all 4 nibbles); then a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
- Backpressure: a=0x00F0, b=0x0F10, out_ready=0 for 5 cycles after out_valid -> sum=0x1000 held stable, in_ready=0; an in_valid pulse with a=0x1111 is ignored. Releasing out_ready -> IDLE next cycle, in_ready=1.
- rst pulsed during the 2nd RUN cycle of a=0xABCD, b=0x1111 -> out_valid never asserts, sum=0, in_ready=1 after rst drops. A following add of 0x0001+0x0002 -> 0x0003.
- Back-to-back: 3 operand pairs with in_valid held high and out_ready=1 -> 3 correct results; each accepted only in IDLE; spacing is NIBBLES+2 cycles.
- With CLA_NIBBLE_SEQ_OVF_EN: 0x7FFF+0x0001 -> sum=0x8000, ovf=1, cout=0; 0x8000+0xFFFF -> sum=0x7FFF, ovf=1, cout=1; 0x0003+0xFFFF -> sum=0x0002, ovf=0, cout=1.
